// File: rtl/audio_sample_poller.sv
// audio_sample_poller: AXI4-Lite read-only master that polls one sample word
// at a fixed tick rate and hands it downstream through a one-entry buffer.
// Optional build macro: AUDIO_SAMPLE_POLLER_STATS_EN enables the overrun counter;
// when undefined, overrun_cnt is tied to zero.
module audio_sample_poller #(
   parameter int unsigned C_M00_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_M00_AXI_ADDR_WIDTH = 4,
   parameter logic [C_M00_AXI_ADDR_WIDTH-1:0] SAMPLE_ADDR = '0,
   parameter int unsigned TICK_DIV = 2500
) (
   input  logic                              m00_axi_aclk,
   input  logic                              m00_axi_areset,
   input  logic                              enable,
   // read address channel
   output logic [C_M00_AXI_ADDR_WIDTH-1:0]   m00_axi_araddr,
   output logic [2:0]                        m00_axi_arprot,
   output logic                              m00_axi_arvalid,
   input  logic                              m00_axi_arready,
   // read data channel
   input  logic [C_M00_AXI_DATA_WIDTH-1:0]   m00_axi_rdata,
   input  logic [1:0]                        m00_axi_rresp,
   input  logic                              m00_axi_rvalid,
   output logic                              m00_axi_rready,
   // write channels, parked
   output logic                              m00_axi_awvalid,
   output logic [C_M00_AXI_ADDR_WIDTH-1:0]   m00_axi_awaddr,
   output logic [2:0]                        m00_axi_awprot,
   output logic                              m00_axi_wvalid,
   output logic [C_M00_AXI_DATA_WIDTH-1:0]   m00_axi_wdata,
   output logic [C_M00_AXI_DATA_WIDTH/8-1:0] m00_axi_wstrb,
   output logic                              m00_axi_bready,
   // downstream sample stream
   output logic [C_M00_AXI_DATA_WIDTH-1:0]   sample_data,
   output logic                              sample_valid,
   input  logic                              sample_ready,
   // status
   output logic                              rd_err,
   output logic                              missed_tick,
   output logic [15:0]                       overrun_cnt
);

   localparam int unsigned CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned DW     = C_M00_AXI_DATA_WIDTH;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic [1:0]  RESP_OKAY = 2'b00;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic            arvalid_q, arvalid_d;
   logic            rready_q, rready_d;
   logic            rd_err_q, rd_err_d;
   logic            missed_q, missed_d;
   logic [DW-1:0]   data_q, data_d;
   logic            valid_q, valid_d;
   logic            tick_c;
   logic            load_c;

   // Constant read address and parked write channels
   assign m00_axi_araddr  = SAMPLE_ADDR;
   assign m00_axi_arprot  = 3'b000;
   assign m00_axi_awvalid = 1'b0;
   assign m00_axi_awaddr  = '0;
   assign m00_axi_awprot  = 3'b000;
   assign m00_axi_wvalid  = 1'b0;
   assign m00_axi_wdata   = '0;
   assign m00_axi_wstrb   = '0;
   assign m00_axi_bready  = 1'b1;

   assign m00_axi_arvalid = arvalid_q;
   assign m00_axi_rready  = rready_q;
   assign sample_data     = data_q;
   assign sample_valid    = valid_q;
   assign rd_err          = rd_err_q;
   assign missed_tick     = missed_q;

   // Sample-rate tick: one-cycle event on the last count of each period
   assign tick_c = enable && (cnt_q == CNT_LAST);

   // Tick counter next value; disabling clears it so the next period starts fresh
   always_comb begin
      cnt_d = cnt_q;
      if (!enable) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Read FSM: one outstanding read, ticks arriving mid-read are dropped
   always_comb begin
      state_d   = state_q;
      arvalid_d = arvalid_q;
      rready_d  = rready_q;
      rd_err_d  = 1'b0;
      missed_d  = missed_q;
      load_c    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (tick_c) begin
               arvalid_d = 1'b1;
               state_d   = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (tick_c) begin
               missed_d = 1'b1;
            end
            if (arvalid_q && m00_axi_arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = ST_DATA;
            end
         end
         ST_DATA: begin
            if (tick_c) begin
               missed_d = 1'b1;
            end
            if (m00_axi_rvalid && rready_q) begin
               rready_d = 1'b0;
               state_d  = ST_IDLE;
               if (m00_axi_rresp == RESP_OKAY) begin
                  load_c = 1'b1;
               end else begin
                  rd_err_d = 1'b1;
               end
            end
         end
         default: begin
            state_d   = ST_IDLE;
            arvalid_d = 1'b0;
            rready_d  = 1'b0;
         end
      endcase
   end

   // One-entry holding buffer; a load wins over a same-cycle consume
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      if (load_c) begin
         data_d  = m00_axi_rdata;
         valid_d = 1'b1;
      end else if (valid_q && sample_ready) begin
         valid_d = 1'b0;
      end
   end

   // State, counter and buffer registers
   always_ff @(posedge m00_axi_aclk or posedge m00_axi_areset) begin
      if (m00_axi_areset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         rd_err_q  <= 1'b0;
         missed_q  <= 1'b0;
         data_q    <= '0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         arvalid_q <= arvalid_d;
         rready_q  <= rready_d;
         rd_err_q  <= rd_err_d;
         missed_q  <= missed_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
      end
   end

`ifdef AUDIO_SAMPLE_POLLER_STATS_EN
   logic [15:0] overrun_q, overrun_d;
   logic        overwrite_c;

   // An overwrite is a load onto an unconsumed sample that is not leaving now
   assign overwrite_c = load_c && valid_q && !sample_ready;

   // Saturating overrun counter next value
   always_comb begin
      overrun_d = overrun_q;
      if (overwrite_c && (overrun_q != 16'hFFFF)) begin
         overrun_d = overrun_q + 16'd1;
      end
   end

   // Overrun counter register
   always_ff @(posedge m00_axi_aclk or posedge m00_axi_areset) begin
      if (m00_axi_areset) begin
         overrun_q <= 16'd0;
      end else begin
         overrun_q <= overrun_d;
      end
   end

   assign overrun_cnt = overrun_q;
`else
   assign overrun_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_audio_sample_poller.sv
// Directed bench for audio_sample_poller with a small AXI4-Lite read slave.
module tb_audio_sample_poller;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 4;
   localparam int unsigned TD = 8;
   localparam logic [AW-1:0] SADDR = 4'h8;
`ifdef AUDIO_SAMPLE_POLLER_STATS_EN
   localparam int unsigned OVR = 1;
`else
   localparam int unsigned OVR = 0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          enable;
   logic [AW-1:0] araddr;
   logic [2:0]    arprot;
   logic          arvalid;
   logic          arready = 1'b0;
   logic [DW-1:0] rdata = '0;
   logic [1:0]    rresp = 2'b00;
   logic          rvalid = 1'b0;
   logic          rready;
   logic          awvalid;
   logic [AW-1:0] awaddr;
   logic [2:0]    awprot;
   logic          wvalid;
   logic [DW-1:0] wdata;
   logic [DW/8-1:0] wstrb;
   logic          bready;
   logic [DW-1:0] sample_data;
   logic          sample_valid;
   logic          sample_ready;
   logic          rd_err;
   logic          missed_tick;
   logic [15:0]   overrun_cnt;

   // slave configuration, written by the stimulus
   int            slv_stall = 0;
   logic [DW-1:0] slv_rdata = '0;
   logic [1:0]    slv_rresp = 2'b00;
   // slave state
   int            slv_st = 0;
   int            slv_ar_seen = 0;

   int total = 0;
   int bad   = 0;
   int nval;

   audio_sample_poller #(
      .C_M00_AXI_DATA_WIDTH(DW),
      .C_M00_AXI_ADDR_WIDTH(AW),
      .SAMPLE_ADDR(SADDR),
      .TICK_DIV(TD)
   ) dut (
      .m00_axi_aclk   (clk),
      .m00_axi_areset (rst),
      .enable         (enable),
      .m00_axi_araddr (araddr),
      .m00_axi_arprot (arprot),
      .m00_axi_arvalid(arvalid),
      .m00_axi_arready(arready),
      .m00_axi_rdata  (rdata),
      .m00_axi_rresp  (rresp),
      .m00_axi_rvalid (rvalid),
      .m00_axi_rready (rready),
      .m00_axi_awvalid(awvalid),
      .m00_axi_awaddr (awaddr),
      .m00_axi_awprot (awprot),
      .m00_axi_wvalid (wvalid),
      .m00_axi_wdata  (wdata),
      .m00_axi_wstrb  (wstrb),
      .m00_axi_bready (bready),
      .sample_data    (sample_data),
      .sample_valid   (sample_valid),
      .sample_ready   (sample_ready),
      .rd_err         (rd_err),
      .missed_tick    (missed_tick),
      .overrun_cnt    (overrun_cnt)
   );

   always #5 clk = ~clk;

   // Read slave: arready after slv_stall cycles of arvalid, rvalid two cycles after the AR handshake
   always @(negedge clk) begin
      if (rst) begin
         slv_st      = 0;
         slv_ar_seen = 0;
         rvalid      = 1'b0;
         arready     = 1'b0;
      end else begin
         if (arvalid) slv_ar_seen++;
         case (slv_st)
            0: begin
               if (rready) begin
                  slv_st      = 1;
                  slv_ar_seen = 0;
               end
            end
            1: begin
               rvalid = 1'b1;
               rdata  = slv_rdata;
               rresp  = slv_rresp;
               slv_st = 2;
            end
            default: begin
               rvalid = 1'b0;
               slv_st = 0;
            end
         endcase
         arready = (slv_ar_seen >= slv_stall);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      enable = 1'b0;
      sample_ready = 1'b0;
      step(2);
      chk("rst_arvalid", 32'(arvalid), 32'd0);
      chk("rst_rready", 32'(rready), 32'd0);
      chk("rst_svalid", 32'(sample_valid), 32'd0);
      chk("rst_sdata", sample_data, 32'd0);
      chk("rst_rderr", 32'(rd_err), 32'd0);
      chk("rst_missed", 32'(missed_tick), 32'd0);
      chk("rst_overrun", 32'(overrun_cnt), 32'd0);
      chk("rst_awvalid", 32'(awvalid), 32'd0);
      chk("rst_wvalid", 32'(wvalid), 32'd0);
      chk("rst_bready", 32'(bready), 32'd1);
      chk("rst_arprot", 32'(arprot), 32'd0);
      chk("rst_araddr", 32'(araddr), 32'(SADDR));
      rst = 1'b0;
      step(2);

      // Periodic reads, immediate consume
      slv_rdata = 32'h0012_3456;
      sample_ready = 1'b1;
      enable = 1'b1;
      step(7);
      chk("s1_first_arvalid_low", 32'(arvalid), 32'd0);
      for (int k = 7; k <= 30; k++) begin
         int j;
         step(1);
         j = (k - 7) % 8;
         chk("s1_arvalid", 32'(arvalid), 32'(j == 0));
         chk("s1_rready", 32'(rready), 32'((j == 1) || (j == 2)));
         chk("s1_svalid", 32'(sample_valid), 32'(j == 3));
         if (j == 3) chk("s1_sdata", sample_data, 32'h0012_3456);
      end
      enable = 1'b0;
      step(4);
      chk("s1_idle_arvalid", 32'(arvalid), 32'd0);
      chk("s1_idle_svalid", 32'(sample_valid), 32'd0);

      // Stalled address channel
      slv_stall = 20;
      slv_rdata = 32'hA5A5_0001;
      enable = 1'b1;
      step(7);
      chk("s2_missed_pre", 32'(missed_tick), 32'd0);
      nval = 0;
      for (int k = 7; k <= 30; k++) begin
         step(1);
         chk("s2_arvalid", 32'(arvalid), 32'(k <= 26));
         if (k <= 26) chk("s2_araddr", 32'(araddr), 32'(SADDR));
         chk("s2_missed", 32'(missed_tick), 32'(k >= 15));
         if (sample_valid) begin
            nval++;
            chk("s2_sdata", sample_data, 32'hA5A5_0001);
         end
      end
      chk("s2_nsamples", 32'(nval), 32'd1);
      enable = 1'b0;
      slv_stall = 0;
      step(4);

      // Error response, then a normal read
      slv_rresp = 2'b10;
      slv_rdata = 32'hDEAD_BEEF;
      enable = 1'b1;
      step(7);
      for (int k = 7; k <= 22; k++) begin
         step(1);
         chk("s3_rderr", 32'(rd_err), 32'(k == 10));
         chk("s3_arvalid", 32'(arvalid), 32'((k == 7) || (k == 15)));
         chk("s3_svalid", 32'(sample_valid), 32'(k == 18));
         if (k == 18) chk("s3_sdata", sample_data, 32'h0000_0055);
         if (k == 11) begin
            slv_rresp = 2'b00;
            slv_rdata = 32'h0000_0055;
         end
      end
      enable = 1'b0;
      step(4);

      // Overwrites with no consumer
      sample_ready = 1'b0;
      slv_rdata = 32'd1;
      enable = 1'b1;
      step(7);
      for (int k = 7; k <= 30; k++) begin
         step(1);
         if (k == 10) begin
            chk("s4_v1", 32'(sample_valid), 32'd1);
            chk("s4_d1", sample_data, 32'd1);
            chk("s4_o1", 32'(overrun_cnt), 32'd0);
            slv_rdata = 32'd2;
         end
         if (k == 18) begin
            chk("s4_d2", sample_data, 32'd2);
            chk("s4_o2", 32'(overrun_cnt), 32'(OVR));
            slv_rdata = 32'd3;
         end
         if (k == 26) begin
            chk("s4_v3", 32'(sample_valid), 32'd1);
            chk("s4_d3", sample_data, 32'd3);
            chk("s4_o3", 32'(overrun_cnt), 32'(2 * OVR));
         end
      end
      enable = 1'b0;
      chk("s4_hold_valid", 32'(sample_valid), 32'd1);
      step(4);

      // Consume on the same cycle as a load
      slv_rdata = 32'h0000_0077;
      enable = 1'b1;
      step(10);
      chk("s5_pre_valid", 32'(sample_valid), 32'd1);
      chk("s5_pre_data", sample_data, 32'd3);
      sample_ready = 1'b1;
      step(1);
      sample_ready = 1'b0;
      chk("s5_valid", 32'(sample_valid), 32'd1);
      chk("s5_data", sample_data, 32'h0000_0077);
      chk("s5_overrun", 32'(overrun_cnt), 32'(2 * OVR));
      step(1);
      chk("s5_valid_hold", 32'(sample_valid), 32'd1);
      step(3);
      enable = 1'b0;
      step(4);

      // Reset in the middle of the data phase
      slv_rdata = 32'h0000_0099;
      enable = 1'b1;
      step(8);
      chk("s6_arvalid", 32'(arvalid), 32'd1);
      step(1);
      chk("s6_rready", 32'(rready), 32'd1);
      chk("s6_svalid_pre", 32'(sample_valid), 32'd1);
      rst = 1'b1;
      #1;
      chk("s6_rst_rready", 32'(rready), 32'd0);
      chk("s6_rst_arvalid", 32'(arvalid), 32'd0);
      chk("s6_rst_svalid", 32'(sample_valid), 32'd0);
      chk("s6_rst_sdata", sample_data, 32'd0);
      chk("s6_rst_missed", 32'(missed_tick), 32'd0);
      chk("s6_rst_overrun", 32'(overrun_cnt), 32'd0);
      step(2);
      rst = 1'b0;
      sample_ready = 1'b1;
      step(7);
      chk("s6_post_arvalid_low", 32'(arvalid), 32'd0);
      step(1);
      chk("s6_post_arvalid", 32'(arvalid), 32'd1);
      step(3);
      chk("s6_post_svalid", 32'(sample_valid), 32'd1);
      chk("s6_post_sdata", sample_data, 32'h0000_0099);
      enable = 1'b0;
      step(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
